one_wire_slave: RTL
===================

// Module: one_wire_slave
// PURPOSE
//  1-Wire responder (slave end): detects bus reset pulses, answers with a presence
//  pulse, receives host write slots into bytes and drives host read slots from a
//  byte loaded by local logic. Bit timing runs in clk ticks (1 tick = 1 us at the
//  design clock). Sits behind the open-drain pad: WireOut=0 pulls low, 1 releases.
// PARAMETERS
//  DATA_WIDTH   8    bits per byte; LSB first on the bus
//  RESET_MIN    400  low ticks that qualify as a bus reset (host drives 480)
//  PRES_WAIT    30   ticks from bus release to presence start
//  PRES_LEN     120  presence pulse length, ticks
//  SAMPLE_PT    30   ticks after a falling edge to sample a write slot
//  DRIVE_LEN    30   ticks this block holds the bus low for a read-slot '0'
//  CNT_W        10   slot counter width; must hold RESET_MIN
// PORTS
//  clk       in   1           clock
//  SRst      in   1           synchronous reset, active high
//  WireIn    in   1           raw bus level (asynchronous)
//  WireOut   out  1           bus drive: 0 = pull low, 1 = release
//  TxData    in   DATA_WIDTH  byte to return in read slots
//  TxLoad    in   1           1-cycle strobe: capture TxData, arm transmit
//  TxBusy    out  1           transmit byte armed or shifting
//  RxData    out  DATA_WIDTH  last complete received byte
//  RxValid   out  1           1-cycle pulse: RxData updated
//  ResetDet  out  1           1-cycle pulse: bus reset qualified
//  RxCrc     out  8           running CRC8 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: WireOut=1, TxBusy=0, RxData=0, RxValid=0, ResetDet=0, RxCrc=0,
//    bit count 0, state IDLE. SRst mid-slot releases bus on the next edge.
//  - WireIn passes a 2-flop synchronizer; all timing counts start at the
//    synchronized falling edge (2-cycle latency vs. raw bus).
//  - States: IDLE, SLOT_LOW, DRIVE, WAIT_HIGH, RST_LOW, PRES_WAIT, PRES_DRIVE.
//  - IDLE: falling edge -> DRIVE if TxBusy and current Tx bit is 0, else SLOT_LOW;
//    counter cleared on entry.
//  - SLOT_LOW (write slot, or read slot with bit 1): at count==SAMPLE_PT, if not
//    TxBusy shift synced WireIn into bit [bitcnt]. Rise before RESET_MIN ->
//    complete bit, IDLE. count==RESET_MIN -> RST_LOW.
//  - DRIVE: WireOut=0 for DRIVE_LEN ticks, then release -> WAIT_HIGH; counter keeps
//    running; count==RESET_MIN -> RST_LOW.
//  - WAIT_HIGH: wait for bus high, complete bit -> IDLE.
//  - Bit completion: bitcnt+1; at bitcnt==DATA_WIDTH-1 wrap to 0 and either
//    pulse RxValid with new RxData (receive) or clear TxBusy (transmit).
//  - RST_LOW: ResetDet pulses once on entry; partial byte discarded, bitcnt=0,
//    TxBusy cleared. On bus high -> PRES_WAIT (PRES_WAIT ticks) -> PRES_DRIVE
//    (WireOut=0 for PRES_LEN ticks) -> release -> IDLE.
//  - TxLoad honoured only in IDLE with bitcnt==0 and TxBusy=0; otherwise ignored.
//  - Falling edge during PRES_WAIT/PRES_DRIVE ignored (own pulse / bus noise).
//  - TxLoad and falling edge in same cycle: load wins, edge starts a read slot
//    using the new byte.
// CONFIGURATION
//  - ONE_WIRE_SLAVE_CRC_EN defined: RxCrc updates per received bit with Dallas
//    CRC8 (x^8+x^5+x^4+1, LSB first, init 0); cleared on ResetDet and SRst.
//    A byte stream ending with its own CRC leaves RxCrc==0.
//  - Not defined: CRC logic absent, RxCrc tied to 8'h00.
// TESTING
//  - Host holds bus low 480 ticks, releases -> ResetDet pulse at qualify point,
//    WireOut low from tick 30 to 150 after release, then 1.
//  - Host writes 8'hA5 (write-1: 6 low, write-0: 60 low) -> one RxValid,
//    RxData=8'hA5, no WireOut activity.
//  - TxLoad with TxData=8'h3C, host issues 8 read slots (6-tick low) -> WireOut
//    low 30 ticks on bits 0,1,6,7 only; TxBusy falls after 8th slot.
//  - Host writes 3 bits then issues 480-tick reset -> no RxValid, ResetDet,
//    presence; next full byte 8'h01 received correctly.
//  - TxLoad while TxBusy=1 with 8'hFF -> ignored, original byte still returned.
//  - CRC_EN: write 8'h02,8'h1C,8'hB8,8'h01,8'h00,8'h00,8'h00,8'hA2 -> RxCrc=0;
//    without macro RxCrc stays 8'h00 throughout.

Source files
------------

// File: rtl/one_wire_slave.sv
// 1-Wire slave: bus reset/presence, write-slot receive, read-slot transmit; ONE_WIRE_SLAVE_CRC_EN adds Dallas CRC8 on RxCrc.
// Latency: 2-flop WireIn synchronizer plus one edge-detect stage; no backpressure, TxLoad is ignored unless idle at a byte boundary.
module one_wire_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int RESET_MIN  = 400,
    parameter int PRES_WAIT  = 30,
    parameter int PRES_LEN   = 120,
    parameter int SAMPLE_PT  = 30,
    parameter int DRIVE_LEN  = 30,
    parameter int CNT_W      = 10
) (
    input  logic                  clk,
    input  logic                  SRst,
    input  logic                  WireIn,
    output logic                  WireOut,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  TxLoad,
    output logic                  TxBusy,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxValid,
    output logic                  ResetDet,
    output logic [7:0]            RxCrc
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SLOT_LOW, S_DRIVE, S_WAIT_HIGH, S_RST_LOW, S_PRES_WAIT, S_PRES_DRIVE
    } state_t;

    state_t                state, state_nxt;
    logic                  w_s1, w_s2, w_s3;
    logic [CNT_W-1:0]      cnt;
    logic [BW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] tx_byte, rx_sh, rx_word;
    logic                  tx_busy, bit_val;
    logic                  fall, load_ok, eff_busy, eff_bit, cur_bit, last_bit;
    logic                  cnt_clr, bit_done, sample_en, enter_rst, wire_out;

    assign fall     = w_s3 & ~w_s2;
    assign load_ok  = TxLoad && (state == S_IDLE) && (bitcnt == '0) && !tx_busy;
    assign eff_busy = tx_busy | load_ok;
    assign eff_bit  = load_ok ? TxData[0] : tx_byte[bitcnt];
    assign last_bit = (bitcnt == BW'(DATA_WIDTH - 1));
    // A slot that rises before the sample point was never sampled: that is a write-1.
    assign cur_bit  = (cnt > CNT_W'(SAMPLE_PT)) ? bit_val : 1'b1;
    assign WireOut  = wire_out;
    assign TxBusy   = tx_busy;

    always_comb begin
        rx_word         = rx_sh;
        rx_word[bitcnt] = cur_bit;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        bit_done  = 1'b0;
        sample_en = 1'b0;
        enter_rst = 1'b0;
        wire_out  = 1'b1;
        case (state)
            S_IDLE: if (fall) begin
                cnt_clr   = 1'b1;
                state_nxt = (eff_busy && !eff_bit) ? S_DRIVE : S_SLOT_LOW;
            end
            S_SLOT_LOW: begin
                sample_en = (cnt == CNT_W'(SAMPLE_PT)) && !tx_busy;
                if (w_s2) begin
                    bit_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(RESET_MIN)) begin
                    enter_rst = 1'b1;
                    state_nxt = S_RST_LOW;
                end
            end
            S_DRIVE: begin
                wire_out = 1'b0;
                if (cnt == CNT_W'(RESET_MIN)) begin
                    enter_rst = 1'b1;
                    state_nxt = S_RST_LOW;
                end else if (cnt == CNT_W'(DRIVE_LEN - 1)) begin
                    state_nxt = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (w_s2) begin
                    bit_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_W'(RESET_MIN)) begin
                    enter_rst = 1'b1;
                    state_nxt = S_RST_LOW;
                end
            end
            S_RST_LOW: if (w_s2) begin
                cnt_clr   = 1'b1;
                state_nxt = S_PRES_WAIT;
            end
            S_PRES_WAIT: if (cnt == CNT_W'(PRES_WAIT - 1)) begin
                cnt_clr   = 1'b1;
                state_nxt = S_PRES_DRIVE;
            end
            S_PRES_DRIVE: begin
                wire_out = 1'b0;
                if (cnt == CNT_W'(PRES_LEN - 1)) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (SRst) begin
            state    <= S_IDLE;
            w_s1     <= 1'b1;
            w_s2     <= 1'b1;
            w_s3     <= 1'b1;
            cnt      <= '0;
            bitcnt   <= '0;
            tx_byte  <= '0;
            tx_busy  <= 1'b0;
            rx_sh    <= '0;
            bit_val  <= 1'b1;
            RxData   <= '0;
            RxValid  <= 1'b0;
            ResetDet <= 1'b0;
        end else begin
            state    <= state_nxt;
            w_s1     <= WireIn;
            w_s2     <= w_s1;
            w_s3     <= w_s2;
            RxValid  <= 1'b0;
            ResetDet <= 1'b0;
            if (cnt_clr)                     cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})   cnt <= cnt + CNT_W'(1);
            if (load_ok) begin
                tx_byte <= TxData;
                tx_busy <= 1'b1;
            end
            if (sample_en) bit_val <= w_s2;
            if (bit_done) begin
                bitcnt <= last_bit ? '0 : bitcnt + BW'(1);
                if (tx_busy) begin
                    if (last_bit) tx_busy <= 1'b0;
                end else begin
                    rx_sh <= rx_word;
                    if (last_bit) begin
                        RxData  <= rx_word;
                        RxValid <= 1'b1;
                    end
                end
            end
            if (enter_rst) begin
                ResetDet <= 1'b1;
                bitcnt   <= '0;
                tx_busy  <= 1'b0;
                rx_sh    <= '0;
            end
        end
    end

`ifdef ONE_WIRE_SLAVE_CRC_EN
    logic [7:0] crc;
    logic       crc_fb;
    assign crc_fb = crc[0] ^ cur_bit;
    always_ff @(posedge clk) begin
        if (SRst || enter_rst)          crc <= 8'h00;
        else if (bit_done && !tx_busy)  crc <= (crc >> 1) ^ (crc_fb ? 8'h8C : 8'h00);
    end
    assign RxCrc = crc;
`else
    assign RxCrc = 8'h00;
`endif
endmodule
